stat_display: RTL
=================

// Module: stat_display
// PURPOSE
//  Consumes the four 32-bit Statistics counters (J, R, I, TotalCycles) and shows one on an
//  8-digit multiplexed seven-segment display. A button steps the selection. The selected
//  counter is snapshotted and converted to 10 BCD digits by an iterative double-dabble
//  engine (1 bit/cycle). The display scan runs continuously. Sits directly downstream of
//  Statistics, on the board I/O side.
// PARAMETERS
//  SCAN_DIV  16  clk cycles each digit stays lit (>=2)
// PORTS
//  clk       in   1   clock, posedge
//  rst       in   1   reset, asynchronous, active-high
//  j_cnt     in   32  J-type count (Statistics.J)
//  r_cnt     in   32  R-type count (Statistics.R)
//  i_cnt     in   32  I-type count (Statistics.I)
//  cyc_cnt   in   32  cycle count (Statistics.TotalCycles)
//  sel_next  in   1   step button, level; rising edge detected internally
//  refresh   in   1   re-convert current selection (sampled while high)
//  sel       out  2   0=J 1=R 2=I 3=Cycles
//  busy      out  1   conversion in progress
//  valid     out  1   bcd holds a completed conversion
//  bcd       out  40  10 BCD digits, [3:0]=units
//  ovf       out  1   value >= 100_000_000 (bcd[39:32]!=0), top digits not displayed
//  an        out  8   digit enables, active-low one-hot, an[0]=units
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset values: sel=0, busy=0, valid=0, bcd=0, ovf=0, an=8'hFE, seg=7'h7F, prescaler=0,
//   digit idx=0, sel_next history=0, pending=1. Reset mid-conversion aborts it with no residue.
//  Edge detect: edge = sel_next & ~sel_next_q. On edge, sel <= sel+1 mod 4 (3->0), in any state.
//  Request: edge | refresh sets pending. Requests in the same cycle or during CONV merge into one.
//  FSM IDLE/CONV:
//   IDLE & (pending|req): bin <= counter[new sel], acc <= 0, it <= 0, pending <= 0, ->CONV.
//     A same-cycle edge uses the incremented sel.
//   CONV, each posedge: every acc nibble >=5 gets +3, then {acc,bin} <<= 1; it++.
//   CONV & it==31: bcd <= final acc, ovf updated, valid <= 1, ->IDLE.
//     A pending request starts on the next posedge.
//  Latency: busy high exactly 32 cycles; bcd updates at start edge + 32. bcd, ovf hold old
//   values during CONV. After reset release, the first conversion starts on the first posedge.
//  Snapshot: counter changes after the start edge do not affect the result.
//  Scan: prescaler counts 0..SCAN_DIV-1; on wrap idx <= idx+1 mod 8; an = ~(8'b1<<idx).
//  seg: hex-to-7seg of bcd digit idx (0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10).
//   Leading zeros above the most significant nonzero digit are blanked (7F); digit0 always
//   shows. When ovf=1, no blanking. seg=7F whenever valid=0.
//  Widths: bin 32b, acc 40b (10 digits); 2^32-1 fits exactly, no truncation inside acc.
// TESTING
//  1 rst 3 cyc, release, sel=0, j_cnt=123 -> busy 32 cyc; bcd=40'h0000000123, valid=1,
//    ovf=0; idx0 seg=30, idx3..7 seg=7F.
//  2 sel_next pulses, each spaced 40 cyc; r=7, i=0, cyc=32'hFFFFFFFF -> sel 1,2,3,0;
//    bcd 7, 0 (idx0 seg=40), 40'h4294967295 with ovf=1 and all digits lit, then back to J.
//  3 change selected counter 123->999 at CONV cycle 5 -> bcd=40'h123.
//  4 during busy: 2 sel_next edges + refresh -> sel +2 immediately; exactly one extra
//    conversion, starting 1 cyc after completion, of the new sel.
//  5 rst at CONV cycle 10 -> all outputs at reset values; on release a new conversion
//    completes 32 cyc after start.
//  6 SCAN_DIV=4 -> an sequence FE,FD,FB,F7,EF,DF,BF,7F,FE, each held 4 cycles.

Source files
------------

// File: rtl/stat_display.sv
// stat_display: shows one of four 32-bit statistics counters on an 8-digit
// multiplexed seven-segment display.
//
// Ports:
//   clk, rst           clock (posedge), asynchronous active-high reset
//   j_cnt/r_cnt/i_cnt  instruction-class counters
//   cyc_cnt            total cycle counter
//   sel_next           step button (level; rising edge steps sel)
//   refresh            re-convert the current selection while high
//   sel                selected counter: 0=J 1=R 2=I 3=Cycles
//   busy               binary-to-BCD conversion in progress
//   valid              bcd holds a completed conversion
//   bcd                10 BCD digits, [3:0]=units
//   ovf                value >= 100_000_000 (top two digits not displayed)
//   an                 digit enables, active-low one-hot, an[0]=units
//   seg                segments {g,f,e,d,c,b,a}, active-low
module stat_display #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] j_cnt,
  input  logic [31:0] r_cnt,
  input  logic [31:0] i_cnt,
  input  logic [31:0] cyc_cnt,
  input  logic        sel_next,
  input  logic        refresh,
  output logic [1:0]  sel,
  output logic        busy,
  output logic        valid,
  output logic [39:0] bcd,
  output logic        ovf,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            sel_next_q;
  logic            pending_q, pending_d;
  logic [31:0]     bin_q, bin_d;
  logic [39:0]     acc_q, acc_d;
  logic [4:0]      it_q, it_d;
  logic [39:0]     bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      idx_q, idx_d;

  logic            edge_det, req;
  logic [39:0]     acc_adj, acc_sh;
  logic [31:0]     bin_sh;
  logic [3:0]      nib;
  logic [3:0]      digit;
  logic [31:0]     upper;
  logic            blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      sel_next_q <= 1'b0;
      pending_q  <= 1'b1;
      bin_q      <= '0;
      acc_q      <= '0;
      it_q       <= '0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sel_next_q <= sel_next;
      pending_q  <= pending_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      it_q       <= it_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
    end
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift {acc,bin} left.
  always_comb begin
    acc_adj = '0;
    nib     = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      nib = acc_q[k*4 +: 4];
      acc_adj[k*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    acc_sh = {acc_adj[38:0], bin_q[31]};
    bin_sh = {bin_q[30:0], 1'b0};
  end

  always_comb begin
    edge_det  = sel_next & ~sel_next_q;
    req       = edge_det | refresh;
    sel_d     = sel_q + {1'b0, edge_det};
    state_d   = state_q;
    pending_d = pending_q;
    bin_d     = bin_q;
    acc_d     = acc_q;
    it_d      = it_q;
    bcd_d     = bcd_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        // Snapshot uses the post-increment selection so a same-cycle step is honoured.
        if (pending_q | req) begin
          case (sel_d)
            2'd0:    bin_d = j_cnt;
            2'd1:    bin_d = r_cnt;
            2'd2:    bin_d = i_cnt;
            default: bin_d = cyc_cnt;
          endcase
          acc_d     = '0;
          it_d      = '0;
          pending_d = 1'b0;
          state_d   = CONV;
        end
      end
      CONV: begin
        pending_d = pending_q | req;
        acc_d     = acc_sh;
        bin_d     = bin_sh;
        it_d      = it_q + 5'd1;
        if (it_q == 5'd31) begin
          bcd_d   = acc_sh;
          ovf_d   = |acc_sh[39:32];
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
  end

  // A digit is a leading zero when it and every displayed digit above it are zero.
  always_comb begin
    digit = bcd_q[{idx_q, 2'b00} +: 4];
    upper = bcd_q[31:0] >> {idx_q, 2'b00};
    blank = !ovf_q && (idx_q != 3'd0) && (upper == 32'd0);
    if (!valid_q || blank) begin
      seg = 7'h7F;
    end else begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end

  assign sel   = sel_q;
  assign busy  = (state_q == CONV);
  assign valid = valid_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
  assign an    = ~(8'b1 << idx_q);

endmodule
